// File: rtl/hist_mem_pkg.sv
// Shared constants and types for the histogram memory responder.
// Covers the address map, control/status bit positions and the FSM state type.
package hist_mem_pkg;

  localparam logic [31:0] BIN_BASE          = 32'h0000_1000;
  localparam logic [31:0] HIST_PIXEL_ADDR   = 32'h0000_2000;
  localparam logic [31:0] HIST_CTRL_ADDR    = 32'h0000_2004;
  localparam logic [31:0] HIST_STATUS_ADDR  = 32'h0000_2008;

  localparam int unsigned BIN_IDX_W         = 8;
  localparam int unsigned PIXEL_W           = 8;

  localparam int unsigned CTRL_CLEAR_BIT      = 0;
  localparam int unsigned CTRL_STICKY_CLR_BIT = 1;

  localparam int unsigned STAT_BUSY_BIT     = 0;
  localparam int unsigned STAT_SAT_BIT      = 1;
  localparam int unsigned STAT_DROP_BIT     = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } hist_state_e;

  // Word address of a byte address; the low two bits never matter on this bus.
  function automatic logic [29:0] word_of(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/hist_bin_bank.sv
// Histogram bin storage: a register array with two async read ports
// (bus and increment path) and one synchronous write port.
module hist_bin_bank
  import hist_mem_pkg::*;
#(
  parameter int unsigned BIN_COUNT = 256,
  parameter int unsigned BIN_W     = 32
) (
  input  logic                 clk,
  input  logic [BIN_IDX_W-1:0] i_bus_idx,
  output logic [BIN_W-1:0]     o_bus_data,
  input  logic [BIN_IDX_W-1:0] i_upd_idx,
  output logic [BIN_W-1:0]     o_upd_data,
  input  logic                 i_we,
  input  logic [BIN_IDX_W-1:0] i_widx,
  input  logic [BIN_W-1:0]     i_wdata
);

  logic [BIN_W-1:0] r_bins [BIN_COUNT];

  assign o_bus_data = r_bins[i_bus_idx];
  assign o_upd_data = r_bins[i_upd_idx];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_bins[i_widx] <= i_wdata;
    end
  end

endmodule

// File: rtl/hist_mem_responder.sv
// Data-port responder for the core: scratch RAM plus a memory-mapped
// 256-bin histogram engine with a clear sweep and sticky sat/drop flags.
module hist_mem_responder
  import hist_mem_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 1024,
  parameter int unsigned BIN_COUNT = 256,
  parameter int unsigned BIN_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        hist_busy
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam logic [BIN_IDX_W-1:0] LAST_IDX = BIN_IDX_W'(BIN_COUNT - 1);

  // Address decode
  logic [29:0]       w_word;
  logic              w_ram_hit;
  logic              w_bin_hit;
  logic              w_pix_sel;
  logic              w_ctrl_sel;
  logic              w_stat_sel;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_unused_ok;

  assign w_word      = word_of(Addr);
  assign w_ram_hit   = (w_word < 30'(RAM_WORDS));
  assign w_bin_hit   = (Addr[31:10] == BIN_BASE[31:10]);
  assign w_pix_sel   = (w_word == word_of(HIST_PIXEL_ADDR));
  assign w_ctrl_sel  = (w_word == word_of(HIST_CTRL_ADDR));
  assign w_stat_sel  = (w_word == word_of(HIST_STATUS_ADDR));
  assign w_ram_idx   = Addr[RAM_AW+1:2];
  assign w_unused_ok = ^Addr[1:0];

  logic w_pix_wr;
  logic w_clr_cmd;
  logic w_sticky_clr;

  assign w_pix_wr     = MemWrite && w_pix_sel;
  assign w_clr_cmd    = MemWrite && w_ctrl_sel && WriteData[CTRL_CLEAR_BIT];
  assign w_sticky_clr = MemWrite && w_ctrl_sel && WriteData[CTRL_STICKY_CLR_BIT];

  // Scratch RAM: async read, sync write, contents survive reset
  logic [31:0] r_ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (MemWrite && w_ram_hit) begin
      r_ram[w_ram_idx] <= WriteData;
    end
  end

  // Histogram engine state
  hist_state_e          r_state;
  logic [BIN_IDX_W-1:0] r_clr_idx;
  logic                 r_p_valid;
  logic [BIN_IDX_W-1:0] r_p_idx;
  logic                 r_sat;
  logic                 r_drop;

  logic [BIN_W-1:0]     w_bus_bin;
  logic [BIN_W-1:0]     w_upd_bin;
  logic                 w_bin_we;
  logic [BIN_IDX_W-1:0] w_bin_widx;
  logic [BIN_W-1:0]     w_bin_wdata;
  logic                 w_sat_evt;
  logic                 w_drop_evt;

  hist_bin_bank #(
    .BIN_COUNT (BIN_COUNT),
    .BIN_W     (BIN_W)
  ) u_bank (
    .clk        (clk),
    .i_bus_idx  (Addr[9:2]),
    .o_bus_data (w_bus_bin),
    .i_upd_idx  (r_p_idx),
    .o_upd_data (w_upd_bin),
    .i_we       (w_bin_we),
    .i_widx     (w_bin_widx),
    .i_wdata    (w_bin_wdata)
  );

  // Bin write mux: the clear sweep owns the port; a pending update is
  // discarded when a clear command lands in the same cycle.
  always_comb begin
    w_bin_we    = 1'b0;
    w_bin_widx  = r_p_idx;
    w_bin_wdata = '0;
    w_sat_evt   = 1'b0;
    if (r_state == CLEAR) begin
      w_bin_we    = 1'b1;
      w_bin_widx  = r_clr_idx;
      w_bin_wdata = '0;
    end else if (r_p_valid && !w_clr_cmd) begin
      w_bin_we = 1'b1;
      if (&w_upd_bin) begin
        w_bin_wdata = w_upd_bin;
        w_sat_evt   = 1'b1;
      end else begin
        w_bin_wdata = w_upd_bin + BIN_W'(1);
      end
    end
  end

  assign w_drop_evt = w_pix_wr && (r_state == CLEAR);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
      r_p_valid <= 1'b0;
      r_p_idx   <= '0;
      r_sat     <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      // Sticky flags: a new event in the clearing cycle still sets them
      if (w_sticky_clr) begin
        r_sat  <= w_sat_evt;
        r_drop <= w_drop_evt;
      end else begin
        r_sat  <= r_sat  | w_sat_evt;
        r_drop <= r_drop | w_drop_evt;
      end

      case (r_state)
        IDLE: begin
          if (w_clr_cmd) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
            r_p_valid <= 1'b0;
          end else begin
            r_p_valid <= w_pix_wr;
            if (w_pix_wr) begin
              r_p_idx <= WriteData[PIXEL_W-1:0];
            end
          end
        end
        CLEAR: begin
          r_p_valid <= 1'b0;
          if (w_clr_cmd) begin
            r_clr_idx <= '0;
          end else if (r_clr_idx == LAST_IDX) begin
            r_state   <= IDLE;
            r_clr_idx <= '0;
          end else begin
            r_clr_idx <= r_clr_idx + BIN_IDX_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign hist_busy = (r_state == CLEAR) || r_p_valid;

  // Read mux
  always_comb begin
    ReadData = '0;
    if (w_ram_hit) begin
      ReadData = r_ram[w_ram_idx];
    end else if (w_bin_hit) begin
      ReadData = 32'(w_bus_bin);
    end else if (w_stat_sel) begin
      ReadData[STAT_BUSY_BIT] = hist_busy;
      ReadData[STAT_SAT_BIT]  = r_sat;
      ReadData[STAT_DROP_BIT] = r_drop;
    end
  end

endmodule

// File: tb/tb_hist_mem_responder.sv
// Directed bench for hist_mem_responder: one default instance and one with
// 4-bit bins sharing the bus (separate store strobes) to reach saturation.
module tb_hist_mem_responder;

  localparam logic [31:0] A_PIX  = 32'h2000;
  localparam logic [31:0] A_CTRL = 32'h2004;
  localparam logic [31:0] A_STAT = 32'h2008;

  logic        clk;
  logic        rst;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        we;
  logic        we4;
  logic [31:0] rd;
  logic [31:0] rd4;
  logic        busy;
  logic        busy4;

  int npass = 0;
  int ntot  = 0;
  int n;

  hist_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .Addr      (Addr),
    .WriteData (WriteData),
    .MemWrite  (we),
    .ReadData  (rd),
    .hist_busy (busy)
  );

  hist_mem_responder #(.BIN_W(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .Addr      (Addr),
    .WriteData (WriteData),
    .MemWrite  (we4),
    .ReadData  (rd4),
    .hist_busy (busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
  endtask

  // sel[0] strobes the default instance, sel[1] the 4-bit instance
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sel);
    @(negedge clk);
    Addr = a; WriteData = d; we = sel[0]; we4 = sel[1];
    @(posedge clk);
    #1;
    we = 1'b0; we4 = 1'b0;
  endtask

  task automatic rd_at(input logic [31:0] a);
    @(negedge clk);
    Addr = a;
    #1;
  endtask

  // Cycles with busy high, sampled now and then 1 ns after each edge
  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; Addr = '0; WriteData = '0; we = 1'b0; we4 = 1'b0;

    // Reset state and initial sweep
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    Addr = A_STAT;
    #1;
    check("rst_status", rd, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    count_busy(n);
    check("init_sweep_len", n, 32'd256);
    rd_at(32'h13FC);
    check("bin255_after_clr", rd, 32'd0);

    // RAM and unmapped space
    store(32'h0010, 32'hDEADBEEF, 2'b11);
    store(32'h0FFC, 32'hA5A5_0F0F, 2'b11);
    store(32'h1154, 32'h1234_5678, 2'b11);
    rd_at(32'h0010);
    check("ram_0010", rd, 32'hDEADBEEF);
    rd_at(32'h0013);
    check("ram_low_bits_ignored", rd, 32'hDEADBEEF);
    rd_at(32'h0FFC);
    check("ram_top", rd, 32'hA5A5_0F0F);
    rd_at(32'h3000);
    check("unmapped_3000", rd, 32'd0);
    rd_at(32'h1154);
    check("bin_store_ignored", rd, 32'd0);

    // Back-to-back pixel updates
    store(A_PIX, 32'h55, 2'b11);
    store(A_PIX, 32'h55, 2'b11);
    store(A_PIX, 32'h55, 2'b11);
    store(A_PIX, 32'h1FF, 2'b11);
    check("busy_pending", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("busy_drops", 32'(busy), 32'd0);
    rd_at(32'h1154);
    check("bin55", rd, 32'd3);
    rd_at(32'h13FC);
    check("binFF", rd, 32'd1);
    rd_at(A_STAT);
    check("status_idle", rd, 32'h0);

    // Clear discards a pending update; pixel during sweep sets drop
    store(A_PIX, 32'h07, 2'b11);
    store(A_CTRL, 32'h1, 2'b11);
    rd_at(32'h101C);
    check("bin7_discarded", rd, 32'd0);
    rd_at(32'h1154);
    check("bin55_not_yet_cleared", rd, 32'd3);
    repeat (8) @(posedge clk);
    store(A_PIX, 32'h07, 2'b11);
    rd_at(A_STAT);
    check("status_drop_busy", rd, 32'h5);
    count_busy(n);
    check("sweep_ends", 32'(busy), 32'd0);
    rd_at(A_STAT);
    check("status_drop", rd, 32'h4);
    rd_at(32'h101C);
    check("bin7_dropped", rd, 32'd0);
    rd_at(32'h1154);
    check("bin55_cleared", rd, 32'd0);
    store(A_CTRL, 32'h2, 2'b11);
    rd_at(A_STAT);
    check("sticky_clr", rd, 32'h0);
    check("sticky_clr_w4", rd4, 32'h0);

    // Saturation on the 4-bit instance
    for (int i = 0; i < 16; i++) store(A_PIX, 32'h02, 2'b10);
    @(posedge clk);
    rd_at(32'h1008);
    check("bin2_sat_w4", rd4, 32'd15);
    rd_at(A_STAT);
    check("status_sat_w4", rd4, 32'h2);
    check("status_other_inst", rd, 32'h0);
    store(A_CTRL, 32'h2, 2'b10);
    rd_at(A_STAT);
    check("sat_cleared_w4", rd4, 32'h0);
    store(A_PIX, 32'h02, 2'b10);
    store(A_CTRL, 32'h2, 2'b10);
    rd_at(A_STAT);
    check("sat_set_wins_w4", rd4, 32'h2);
    store(A_CTRL, 32'h2, 2'b10);
    rd_at(A_STAT);
    check("sat_recleared_w4", rd4, 32'h0);

    // Clear restart mid-sweep
    store(A_CTRL, 32'h1, 2'b11);
    repeat (99) @(posedge clk);
    store(A_CTRL, 32'h1, 2'b11);
    count_busy(n);
    check("restart_sweep_len", n, 32'd256);

    // Reset mid-sweep
    store(A_CTRL, 32'h1, 2'b11);
    repeat (20) @(posedge clk);
    store(A_PIX, 32'h11, 2'b11);
    rd_at(A_STAT);
    check("drop_before_rst", rd, 32'h5);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    Addr = A_STAT;
    #1;
    check("status_after_rst", rd, 32'h1);
    check("status_after_rst_w4", rd4, 32'h1);
    count_busy(n);
    check("rst_sweep_len", n, 32'd256);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
